md5_msg_sched: RTL

- Message-word scheduler for the MD5 round core.
- Accepts one 512-bit block as 16 words over a valid/ready load stream and stores them in a 16-entry register buffer.
- On start, streams the 64 per-round message words M[g(i)] to the round datapath in round order i = 0..63, where g is the MD5 message index.
- Sits between the block loader and the compression pipeline; the buffer side of the same index path the round core uses.

---
 rtl/md5_msg_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/md5_msg_sched.sv
// MD5 message-word scheduler: buffers a 16-word block, then streams M[g(i)] for rounds 0..63.
// Build option MD5_MSG_BSWAP_EN: byte-reverse each accepted word before storage.
module md5_msg_sched #(
  parameter int DATA_W     = 32,
  parameter bit AUTO_START = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] out_word,
  output logic [5:0]        out_idx,
  output logic [3:0]        out_g,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshakes: a word moves on a cycle where valid && ready at the rising clk edge;
  // the source holds data stable while valid is high and ready is low.

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [5:0]        round_q, round_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [16];
  logic [DATA_W-1:0] mem_d [16];
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        g_idx;
  logic [3:0]        i4;
  logic              load_fire;
  logic              run_fire;

  always_comb begin
    wr_data = in_data;
`ifdef MD5_MSG_BSWAP_EN
    for (int b = 0; b < DATA_W / 8; b++) begin
      wr_data[8*b +: 8] = in_data[DATA_W-8-8*b +: 8];
    end
`endif
  end

  // Only the low 4 bits of each product matter, so 4-bit arithmetic is the mod 16.
  always_comb begin
    i4 = round_q[3:0];
    case (round_q[5:4])
      2'd0:    g_idx = i4;
      2'd1:    g_idx = i4 * 4'd5 + 4'd1;
      2'd2:    g_idx = i4 * 4'd3 + 4'd5;
      default: g_idx = i4 * 4'd7;
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_FULL) || (state_q == ST_RUN);
  assign out_valid = (state_q == ST_RUN);
  assign out_idx   = round_q;
  assign out_g     = g_idx;
  assign out_word  = out_valid ? mem_q[g_idx] : '0;
  assign done      = done_q;
  assign dbg_state = state_q;

  assign load_fire = in_valid && in_ready;
  assign run_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    round_d = round_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
    case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          mem_d[wcnt_q] = wr_data;
          wcnt_d        = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d = AUTO_START ? ST_RUN : ST_FULL;
            round_d = 6'd0;
          end
        end
      end
      ST_FULL: begin
        if (start) begin
          state_d = ST_RUN;
          round_d = 6'd0;
        end
      end
      ST_RUN: begin
        if (run_fire) begin
          round_d = round_q + 6'd1;
          if (round_q == 6'd63) begin
            state_d = ST_LOAD;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      wcnt_q  <= 4'd0;
      round_q <= 6'd0;
      done_q  <= 1'b0;
      for (int k = 0; k < 16; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      round_q <= round_d;
      done_q  <= done_d;
      for (int k = 0; k < 16; k++) mem_q[k] <= mem_d[k];
    end
  end

endmodule
